// File: rtl/nested_int_ctrl.sv
// ---------------------------------------------------------------------------
// nested_int_ctrl
//   Nesting interrupt controller for the 5-stage core. It latches rising edges
//   of N_SRC request lines and arbitrates them by fixed priority (the highest
//   index wins). It redirects the pipeline to a per-source vector and keeps an
//   EPC / source stack, so a higher-priority source can pre-empt a running
//   handler. ERET pops one level of that stack.
//
//   Optional build macro: INT_SYNC_EN
//     Defined   : irq_in passes a 2-flop synchroniser before edge detection.
//     Undefined : irq_in is assumed synchronous to clk and is sampled directly.
//
// Ports
//   clk, rst     core clock, asynchronous active-high reset
//   irq_in       raw request levels
//   pipe_ready   pipeline may be redirected this cycle
//   pc_resume    PC saved as EPC when an interrupt is taken this cycle
//   eret         ERET decoded in ID
//   ie_wr_en/ie_wr_data  global interrupt enable write
//   int_take     1-cycle pulse, redirect to int_vec
//   int_vec      handler address, valid while int_take
//   eret_take    1-cycle pulse, redirect to ret_pc
//   ret_pc       popped EPC, valid while eret_take
//   eret_err     1-cycle pulse, ERET with an empty stack
//   ie           global interrupt enable
//   pending      latched requests that have not been taken yet
//   in_service   sources whose handlers are active
//   depth        current nesting level
// ---------------------------------------------------------------------------
module nested_int_ctrl #(
  parameter int unsigned N_SRC = 3,
  parameter int unsigned ADDR_W = 32,
  parameter logic [ADDR_W-1:0] VEC_BASE = ADDR_W'(32'h0000_2000),
  parameter logic [ADDR_W-1:0] VEC_STRIDE = ADDR_W'(32'h0000_0100),
  localparam int unsigned DW = $clog2(N_SRC + 1),
  localparam int unsigned SW = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_SRC-1:0]  irq_in,
  input  logic              pipe_ready,
  input  logic [ADDR_W-1:0] pc_resume,
  input  logic              eret,
  input  logic              ie_wr_en,
  input  logic              ie_wr_data,
  output logic              int_take,
  output logic [ADDR_W-1:0] int_vec,
  output logic              eret_take,
  output logic [ADDR_W-1:0] ret_pc,
  output logic              eret_err,
  output logic              ie,
  output logic [N_SRC-1:0]  pending,
  output logic [N_SRC-1:0]  in_service,
  output logic [DW-1:0]     depth
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_ENTER = 2'd1,
    ST_LEAVE = 2'd2
  } state_t;

  // Request lines as seen by the edge detector
  logic [N_SRC-1:0] irq_s;

`ifdef INT_SYNC_EN
  logic [N_SRC-1:0] sync1_q, sync1_d;
  logic [N_SRC-1:0] sync2_q, sync2_d;

  // Synchroniser next-state
  always_comb begin
    sync1_d = irq_in;
    sync2_d = sync1_q;
  end

  // Two-flop synchroniser for asynchronous request lines
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  assign irq_s = sync2_q;
`else
  assign irq_s = irq_in;
`endif

  state_t              state_q, state_d;
  logic [N_SRC-1:0]    irq_prev_q, irq_prev_d;
  logic [N_SRC-1:0]    pending_q, pending_d;
  logic [N_SRC-1:0]    in_service_q, in_service_d;
  logic [DW-1:0]       depth_q, depth_d;
  logic                ie_q, ie_d;
  logic                int_take_q, int_take_d;
  logic [ADDR_W-1:0]   int_vec_q, int_vec_d;
  logic                eret_take_q, eret_take_d;
  logic [ADDR_W-1:0]   ret_pc_q, ret_pc_d;
  logic                eret_err_q, eret_err_d;
  logic [ADDR_W-1:0]   stack_epc_q [N_SRC];
  logic [ADDR_W-1:0]   stack_epc_d [N_SRC];
  logic [SW-1:0]       stack_src_q [N_SRC];
  logic [SW-1:0]       stack_src_d [N_SRC];

  logic [N_SRC-1:0]    edge_s;
  logic [SW-1:0]       hp_idx_s, hs_idx_s, pop_src_s, push_ptr_s, pop_ptr_s;
  logic                hp_vld_s, hs_vld_s, hp_gt_hs_s;
  logic                qualify_s, do_pop_s, do_err_s;
  logic [DW-1:0]       top_s;

  // Arbitration, qualification and the next state of every flop
  always_comb begin
    irq_prev_d = irq_s;
    edge_s     = irq_s & ~irq_prev_q;

    // Highest pending and highest in-service index; the later (higher) index overrides
    hp_idx_s = '0;
    hp_vld_s = 1'b0;
    hs_idx_s = '0;
    hs_vld_s = 1'b0;
    for (int i = 0; i < N_SRC; i++) begin
      hp_idx_s = pending_q[i]    ? SW'(i) : hp_idx_s;
      hp_vld_s = hp_vld_s | pending_q[i];
      hs_idx_s = in_service_q[i] ? SW'(i) : hs_idx_s;
      hs_vld_s = hs_vld_s | in_service_q[i];
    end
    hp_gt_hs_s = hp_vld_s && (!hs_vld_s || (hp_idx_s > hs_idx_s));

    qualify_s = (state_q == ST_RUN) && ie_q && hp_gt_hs_s && pipe_ready && !eret;
    do_pop_s  = (state_q == ST_RUN) && eret && pipe_ready && (depth_q != '0);
    do_err_s  = (state_q == ST_RUN) && eret && pipe_ready && (depth_q == '0);

    top_s      = depth_q - DW'(1'b1);
    push_ptr_s = SW'(depth_q);
    pop_ptr_s  = SW'(top_s);
    pop_src_s  = stack_src_q[pop_ptr_s];

    // Defaults: hold state, drop pulses, and keep latching new edges
    state_d      = state_q;
    pending_d    = pending_q | edge_s;
    in_service_d = in_service_q;
    depth_d      = depth_q;
    ie_d         = ie_wr_en ? ie_wr_data : ie_q;
    int_take_d   = 1'b0;
    int_vec_d    = int_vec_q;
    eret_take_d  = 1'b0;
    ret_pc_d     = ret_pc_q;
    eret_err_d   = 1'b0;
    stack_epc_d  = stack_epc_q;
    stack_src_d  = stack_src_q;

    case (state_q)
      ST_RUN: begin
        // ERET has priority over a request that qualifies in the same cycle
        if (do_pop_s) begin
          in_service_d[pop_src_s] = 1'b0;
          depth_d                 = top_s;
          eret_take_d             = 1'b1;
          ret_pc_d                = stack_epc_q[pop_ptr_s];
          state_d                 = ST_LEAVE;
        end else if (qualify_s) begin
          stack_epc_d[push_ptr_s] = pc_resume;
          stack_src_d[push_ptr_s] = hp_idx_s;
          in_service_d[hp_idx_s]  = 1'b1;
          // The take clears the bit; a fresh edge in the same cycle keeps it set
          pending_d[hp_idx_s]     = edge_s[hp_idx_s];
          depth_d                 = depth_q + DW'(1'b1);
          int_take_d              = 1'b1;
          int_vec_d               = VEC_BASE + (ADDR_W'(hp_idx_s) * VEC_STRIDE);
          state_d                 = ST_ENTER;
        end else begin
          eret_err_d = do_err_s;
          state_d    = ST_RUN;
        end
      end
      ST_ENTER: state_d = ST_RUN;
      ST_LEAVE: state_d = ST_RUN;
      default:  state_d = ST_RUN;
    endcase
  end

  // Controller state, stack and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_RUN;
      irq_prev_q   <= '0;
      pending_q    <= '0;
      in_service_q <= '0;
      depth_q      <= '0;
      ie_q         <= 1'b1;
      int_take_q   <= 1'b0;
      int_vec_q    <= '0;
      eret_take_q  <= 1'b0;
      ret_pc_q     <= '0;
      eret_err_q   <= 1'b0;
      for (int i = 0; i < N_SRC; i++) begin
        stack_epc_q[i] <= '0;
        stack_src_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      irq_prev_q   <= irq_prev_d;
      pending_q    <= pending_d;
      in_service_q <= in_service_d;
      depth_q      <= depth_d;
      ie_q         <= ie_d;
      int_take_q   <= int_take_d;
      int_vec_q    <= int_vec_d;
      eret_take_q  <= eret_take_d;
      ret_pc_q     <= ret_pc_d;
      eret_err_q   <= eret_err_d;
      for (int i = 0; i < N_SRC; i++) begin
        stack_epc_q[i] <= stack_epc_d[i];
        stack_src_q[i] <= stack_src_d[i];
      end
    end
  end

  assign int_take   = int_take_q;
  assign int_vec    = int_vec_q;
  assign eret_take  = eret_take_q;
  assign ret_pc     = ret_pc_q;
  assign eret_err   = eret_err_q;
  assign ie         = ie_q;
  assign pending    = pending_q;
  assign in_service = in_service_q;
  assign depth      = depth_q;

endmodule

// File: tb/tb_nested_int_ctrl.sv
// ---------------------------------------------------------------------------
// tb_nested_int_ctrl
//   Directed bench for nested_int_ctrl with N_SRC=3 and the default vectors.
//   Inputs change 1 ns after a rising edge, and outputs are checked at the
//   same point, once the registered values have settled.
// ---------------------------------------------------------------------------
module tb_nested_int_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  irq_in;
  logic        pipe_ready;
  logic [31:0] pc_resume;
  logic        eret;
  logic        ie_wr_en;
  logic        ie_wr_data;
  logic        int_take;
  logic [31:0] int_vec;
  logic        eret_take;
  logic [31:0] ret_pc;
  logic        eret_err;
  logic        ie;
  logic [2:0]  pending;
  logic [2:0]  in_service;
  logic [1:0]  depth;

  int n_checks = 0;
  int n_fail   = 0;

  nested_int_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .irq_in     (irq_in),
    .pipe_ready (pipe_ready),
    .pc_resume  (pc_resume),
    .eret       (eret),
    .ie_wr_en   (ie_wr_en),
    .ie_wr_data (ie_wr_data),
    .int_take   (int_take),
    .int_vec    (int_vec),
    .eret_take  (eret_take),
    .ret_pc     (ret_pc),
    .eret_err   (eret_err),
    .ie         (ie),
    .pending    (pending),
    .in_service (in_service),
    .depth      (depth)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  // One-cycle ERET, leaving the bench right after the edge that accepts it
  task automatic do_eret();
    eret = 1'b1;
    step();
    eret = 1'b0;
  endtask

  initial begin
    rst = 1'b1; irq_in = 3'b000; pipe_ready = 1'b1; pc_resume = 32'h0;
    eret = 1'b0; ie_wr_en = 1'b0; ie_wr_data = 1'b0;
    step(); step();
    check("rst_ie", {31'd0, ie}, 32'd1);
    check("rst_pending", {29'd0, pending}, 32'd0);
    check("rst_in_service", {29'd0, in_service}, 32'd0);
    check("rst_depth", {30'd0, depth}, 32'd0);
    check("rst_int_take", {31'd0, int_take}, 32'd0);
    check("rst_int_vec", int_vec, 32'd0);
    check("rst_ret_pc", ret_pc, 32'd0);
    rst = 1'b0;
    step();

    // Source 0 taken two cycles after its edge
    pc_resume = 32'h40; irq_in = 3'b001;
    step();
    check("s1_pending", {29'd0, pending}, 32'b001);
    check("s1_no_take_yet", {31'd0, int_take}, 32'd0);
    step();
    check("s1_take", {31'd0, int_take}, 32'd1);
    check("s1_vec", int_vec, 32'h2000);
    check("s1_in_service", {29'd0, in_service}, 32'b001);
    check("s1_depth", {30'd0, depth}, 32'd1);
    check("s1_pending_clr", {29'd0, pending}, 32'd0);
    step();
    check("s1_take_pulse", {31'd0, int_take}, 32'd0);

    // Source 2 pre-empts handler 0, then two ERETs unwind the stack
    pc_resume = 32'h2008; irq_in = 3'b101;
    step();
    check("s2_pending", {29'd0, pending}, 32'b100);
    step();
    check("s2_take", {31'd0, int_take}, 32'd1);
    check("s2_vec", int_vec, 32'h2200);
    check("s2_depth", {30'd0, depth}, 32'd2);
    check("s2_in_service", {29'd0, in_service}, 32'b101);
    step();
    do_eret();
    check("s2_eret1_take", {31'd0, eret_take}, 32'd1);
    check("s2_eret1_pc", ret_pc, 32'h2008);
    check("s2_eret1_depth", {30'd0, depth}, 32'd1);
    check("s2_eret1_in_service", {29'd0, in_service}, 32'b001);
    check("s2_eret1_no_int", {31'd0, int_take}, 32'd0);
    step();
    check("s2_eret_pulse", {31'd0, eret_take}, 32'd0);
    do_eret();
    check("s2_eret2_take", {31'd0, eret_take}, 32'd1);
    check("s2_eret2_pc", ret_pc, 32'h40);
    check("s2_eret2_depth", {30'd0, depth}, 32'd0);
    check("s2_eret2_in_service", {29'd0, in_service}, 32'd0);
    step();
    irq_in = 3'b000;
    step();

    // Lower-priority source 1 waits behind handler 2
    pc_resume = 32'h100; irq_in = 3'b100;
    step(); step();
    check("s3_take2", {31'd0, int_take}, 32'd1);
    check("s3_vec2", int_vec, 32'h2200);
    step();
    irq_in = 3'b110;
    step();
    check("s3_pending1", {29'd0, pending}, 32'b010);
    step(); step();
    check("s3_blocked", {31'd0, int_take}, 32'd0);
    check("s3_still_pending", {29'd0, pending}, 32'b010);
    do_eret();
    check("s3_eret_take", {31'd0, eret_take}, 32'd1);
    check("s3_eret_pc", ret_pc, 32'h100);
    check("s3_eret_depth", {30'd0, depth}, 32'd0);
    step();
    check("s3_leave_no_take", {31'd0, int_take}, 32'd0);
    step();
    check("s3_take1", {31'd0, int_take}, 32'd1);
    check("s3_vec1", int_vec, 32'h2100);
    check("s3_in_service1", {29'd0, in_service}, 32'b010);
    step();
    do_eret();
    step();
    irq_in = 3'b000;
    step();

    // All three at once: taken 2, 1, 0, each only after the previous ERET
    irq_in = 3'b111;
    step();
    check("s4_pending_all", {29'd0, pending}, 32'b111);
    step();
    check("s4_take2", int_vec, 32'h2200);
    check("s4_pending_after2", {29'd0, pending}, 32'b011);
    step(); step();
    check("s4_no_nest", {31'd0, int_take}, 32'd0);
    do_eret();
    step(); step();
    check("s4_take1", {31'd0, int_take}, 32'd1);
    check("s4_vec1", int_vec, 32'h2100);
    check("s4_pending_after1", {29'd0, pending}, 32'b001);
    step();
    do_eret();
    step(); step();
    check("s4_take0", {31'd0, int_take}, 32'd1);
    check("s4_vec0", int_vec, 32'h2000);
    check("s4_pending_empty", {29'd0, pending}, 32'd0);
    step();
    do_eret();
    check("s4_final_depth", {30'd0, depth}, 32'd0);
    step();
    irq_in = 3'b000;
    step();

    // ERET with an empty stack, then interrupts masked by ie
    do_eret();
    check("s5_eret_err", {31'd0, eret_err}, 32'd1);
    check("s5_no_eret_take", {31'd0, eret_take}, 32'd0);
    check("s5_depth", {30'd0, depth}, 32'd0);
    step();
    check("s5_err_pulse", {31'd0, eret_err}, 32'd0);
    ie_wr_en = 1'b1; ie_wr_data = 1'b0;
    step();
    ie_wr_en = 1'b0;
    check("s5_ie_off", {31'd0, ie}, 32'd0);
    irq_in = 3'b010;
    step();
    check("s5_pending_masked", {29'd0, pending}, 32'b010);
    step(); step();
    check("s5_no_take_masked", {31'd0, int_take}, 32'd0);
    ie_wr_en = 1'b1; ie_wr_data = 1'b1;
    step();
    ie_wr_en = 1'b0;
    check("s5_ie_on", {31'd0, ie}, 32'd1);
    check("s5_no_take_same_cycle", {31'd0, int_take}, 32'd0);
    step();
    check("s5_take_after_ie", {31'd0, int_take}, 32'd1);
    check("s5_vec", int_vec, 32'h2100);
    step();
    do_eret();
    step();
    irq_in = 3'b000;
    step();

    // ERET and a qualifying request in the same cycle, then reset during ENTER
    pc_resume = 32'h80; irq_in = 3'b001;
    step(); step();
    check("s6_take0", int_vec, 32'h2000);
    step();
    pipe_ready = 1'b0; irq_in = 3'b101;
    step();
    check("s6_pending2", {29'd0, pending}, 32'b100);
    step();
    check("s6_no_take_not_ready", {31'd0, int_take}, 32'd0);
    pipe_ready = 1'b1;
    do_eret();
    check("s6_eret_wins", {31'd0, eret_take}, 32'd1);
    check("s6_no_int_with_eret", {31'd0, int_take}, 32'd0);
    check("s6_ret_pc", ret_pc, 32'h80);
    check("s6_depth0", {30'd0, depth}, 32'd0);
    step();
    check("s6_leave_no_take", {31'd0, int_take}, 32'd0);
    step();
    check("s6_take2", {31'd0, int_take}, 32'd1);
    check("s6_vec2", int_vec, 32'h2200);
    check("s6_depth1", {30'd0, depth}, 32'd1);
    rst = 1'b1; irq_in = 3'b000;
    #1;
    check("s6_rst_int_take", {31'd0, int_take}, 32'd0);
    check("s6_rst_int_vec", int_vec, 32'd0);
    check("s6_rst_depth", {30'd0, depth}, 32'd0);
    check("s6_rst_in_service", {29'd0, in_service}, 32'd0);
    check("s6_rst_pending", {29'd0, pending}, 32'd0);
    check("s6_rst_ie", {31'd0, ie}, 32'd1);
    step();
    rst = 1'b0;
    step();
    check("s6_post_rst_idle", {31'd0, int_take}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
